// File: rtl/ucmp_rr_sched_if.sv
// Requester and response bundle for the shared unsigned comparator.
// slave is the scheduler side, master is the client/consumer side.
interface ucmp_rr_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_val;
    logic [NREQ-1:0]       req_rdy;
    logic [NREQ*WIDTH-1:0] req_in0;
    logic [NREQ*WIDTH-1:0] req_in1;
    logic                  resp_val;
    logic                  resp_rdy;
    logic [IDW-1:0]        resp_id;
    logic                  resp_lt;
    logic                  resp_eq;
    logic                  resp_gt;

    modport slave (
        input  req_val, req_in0, req_in1, resp_rdy,
        output req_rdy, resp_val, resp_id, resp_lt, resp_eq, resp_gt
    );

    modport master (
        output req_val, req_in0, req_in1, resp_rdy,
        input  req_rdy, resp_val, resp_id, resp_lt, resp_eq, resp_gt
    );
endinterface

// File: rtl/ucmp_rr_sched.sv
// Round-robin scheduler sharing one unsigned lt/eq/gt comparator.
// Optional UCMP_RR_SCHED_STATS_EN adds a saturating handshake counter.
module ucmp_rr_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    ucmp_rr_sched_if.slave bus
`ifdef UCMP_RR_SCHED_STATS_EN
    ,
    output logic [15:0]    stat_cnt
`endif
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] in0_q, in0_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    logic             gnt_vld;
    logic [IDW-1:0]   gnt;

    // Scan downward so the requester closest to ptr is the last writer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (bus.req_val[idx]) begin
                gnt_vld = 1'b1;
                gnt     = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        in0_d        = in0_q;
        in1_d        = in1_q;
        lt_d         = lt_q;
        eq_d         = eq_q;
        gt_d         = gt_q;
        bus.req_rdy  = '0;
        bus.resp_val = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld && !reset) begin
                    bus.req_rdy = NREQ'(1) << gnt;
                    id_d        = gnt;
                    in0_d       = bus.req_in0[gnt*WIDTH +: WIDTH];
                    in1_d       = bus.req_in1[gnt*WIDTH +: WIDTH];
                    ptr_d       = (gnt == IDW'(NREQ - 1)) ? '0
                                                          : gnt + IDW'(1);
                    state_d     = CMP;
                end
            end
            CMP: begin
                lt_d    = in0_q <  in1_q;
                eq_d    = in0_q == in1_q;
                gt_d    = in0_q >  in1_q;
                state_d = RESP;
            end
            RESP: begin
                bus.resp_val = 1'b1;
                if (bus.resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign bus.resp_id = id_q;
    assign bus.resp_lt = lt_q;
    assign bus.resp_eq = eq_q;
    assign bus.resp_gt = gt_q;

`ifdef UCMP_RR_SCHED_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.resp_val && bus.resp_rdy && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stat_cnt = cnt_q;
`endif
endmodule
